// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 mux: FSM state encoding and the
// elaboration-time parameter sanity check.
package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mux_state_t;

    // True when the select field can address every input and NUM_IN is in range.
    function automatic bit sel_width_ok(input int sel_w, input int num_in);
        return (num_in >= 2) && (num_in <= 16) && ((1 << sel_w) >= num_in);
    endfunction

endpackage

// File: rtl/mux_nx1_reg_if.sv
// Ready/valid bundle for the registered N:1 mux: input side (bus + select) and
// output side (selected word + range error).
interface mux_nx1_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 4
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_bus, sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_bus, sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/mux_nx1_sel.sv
// Combinational N:1 word select; out-of-range indices yield zero with err set.
module mux_nx1_sel #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 4
) (
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        word,
    output logic                    err
);
    logic [WIDTH-1:0] words [NUM_IN];

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_split
        assign words[gi] = in_bus[gi*WIDTH +: WIDTH];
    end

    // Compare against each legal index so a select beyond NUM_IN-1 never indexes the array.
    always_comb begin
        word = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                word = words[k];
                err  = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 mux with ready/valid on both sides; a main register drives the
// outputs and a skid register absorbs one extra word under back-pressure.
module mux_nx1_reg
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_nx1_reg_if.slave bus
);
    localparam bit PARAMS_OK = sel_width_ok(SEL_W, NUM_IN);

    if (!PARAMS_OK) begin : g_param_check
        $error("mux_nx1_reg: need 2 <= NUM_IN <= 16 and 2**SEL_W >= NUM_IN");
    end

    mux_state_t       state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_err_q, main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic             in_xfer;
    logic             out_xfer;

    mux_nx1_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_bus (bus.in_bus),
        .sel    (bus.sel),
        .word   (sel_word),
        .err    (sel_err)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_data_q;
    assign bus.out_err   = main_err_q;

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_data_d = sel_word;
                    main_err_d  = sel_err;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = sel_word;
                    main_err_d  = sel_err;
                end else if (in_xfer) begin
                    skid_data_d = sel_word;
                    skid_err_d  = sel_err;
                    state_d     = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Ready depends only on where the FSM lands, never on out_ready.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
        end
    end
endmodule
